id_ctrl_stage: RTL and testbench

Pipelined, parametrised successor to the single-cycle control32 decoder for the Minisys-1A core. It sits between IF and EX, decodes the 32-bit instruction into a registered control bundle, and holds issue for load-use hazards and multi-cycle divides. Both ends use a valid/ready handshake.

---
 rtl/id_ctrl_stage.sv | 265 ++++++++++++++++++++++++++
 tb/tb_id_ctrl_stage.sv | 594 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: registered MIPS control decode between IF and EX with load-use and divide holds.
// Define CTRL_EXC_EN to decode exc (rsvd/eret/syscall/break) and mfc0/mtc0; otherwise they decode as NOPs.
module id_ctrl_stage #(
    parameter int DIV_CYCLES      = 32,
    parameter int LU_STALL_CYCLES = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    input  logic        flush,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        regdst,
    output logic        alusrc,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        mem_sign,
    output logic [1:0]  mem_dwidth,
    output logic [1:0]  aluop,
    output logic        jmp,
    output logic        jal,
    output logic        jr,
    output logic        jalr,
    output logic        sftmd,
    output logic        div,
    output logic        mfhi,
    output logic        mflo,
    output logic        mthi,
    output logic        mtlo,
    output logic        mfc0,
    output logic        mtc0,
    output logic [7:0]  br,
    output logic [3:0]  exc,
    output logic        div_busy
);

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       mem_sign;
        logic [1:0] mem_dwidth;
        logic [1:0] aluop;
        logic       jmp;
        logic       jal;
        logic       jr;
        logic       jalr;
        logic       sftmd;
        logic       div;
        logic       mfhi;
        logic       mflo;
        logic       mthi;
        logic       mtlo;
        logic       mfc0;
        logic       mtc0;
        logic [7:0] br;
        logic [3:0] exc;
    } ctrl_t;

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        DIV_WAIT
    } state_t;

    localparam int MAXC = (DIV_CYCLES > LU_STALL_CYCLES) ? DIV_CYCLES : LU_STALL_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       unused_bits;

    assign op          = instruction[31:26];
    assign rs          = instruction[25:21];
    assign rt          = instruction[20:16];
    assign funct       = instruction[5:0];
    assign unused_bits = ^instruction[15:6];

    ctrl_t d;
    logic  rsvd;

    always_comb begin
        d    = '0;
        rsvd = 1'b0;
        case (op)
            6'h00: begin
                if (funct == 6'h0C) begin
                    d.exc[1] = 1'b1;
                end else if (funct == 6'h0D) begin
                    d.exc[0] = 1'b1;
                end else begin
                    d.regdst   = 1'b1;
                    d.aluop    = 2'b10;
                    d.sftmd    = funct inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
                    d.div      = funct inside {6'h1A, 6'h1B};
                    d.jr       = (funct == 6'h08);
                    d.jalr     = (funct == 6'h09);
                    d.mfhi     = (funct == 6'h10);
                    d.mthi     = (funct == 6'h11);
                    d.mflo     = (funct == 6'h12);
                    d.mtlo     = (funct == 6'h13);
                    d.regwrite = !(d.jr | d.mthi | d.mtlo | d.div);
                end
            end
            6'h01: begin
                d.aluop = 2'b01;
                case (rt)
                    5'h00:   d.br[5] = 1'b1;
                    5'h01:   d.br[4] = 1'b1;
                    5'h10: begin
                        d.br[7]    = 1'b1;
                        d.regwrite = 1'b1;
                    end
                    5'h11: begin
                        d.br[6]    = 1'b1;
                        d.regwrite = 1'b1;
                    end
                    default: rsvd = 1'b1;
                endcase
            end
            6'h02: d.jmp = 1'b1;
            6'h03: begin
                d.jal      = 1'b1;
                d.regwrite = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                d.aluop        = 2'b01;
                d.br[op[1:0]]  = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                d.alusrc   = 1'b1;
                d.regwrite = 1'b1;
                d.aluop    = 2'b10;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                d.alusrc     = 1'b1;
                d.regwrite   = 1'b1;
                d.memread    = 1'b1;
                d.mem_sign   = !op[2];
                d.mem_dwidth = (op[1:0] == 2'b11) ? 2'b11 : {1'b0, op[0]};
            end
            6'h28, 6'h29, 6'h2B: begin
                d.alusrc     = 1'b1;
                d.memwrite   = 1'b1;
                d.mem_dwidth = (op[1:0] == 2'b11) ? 2'b11 : {1'b0, op[0]};
            end
            6'h10: begin
                if (rs == 5'h00) begin
                    d.mfc0     = 1'b1;
                    d.regwrite = 1'b1;
                end else if (rs == 5'h04) begin
                    d.mtc0 = 1'b1;
                end else if (rs == 5'h10 && funct == 6'h18) begin
                    d.exc[2] = 1'b1;
                end else begin
                    rsvd = 1'b1;
                end
            end
            default: rsvd = 1'b1;
        endcase
`ifdef CTRL_EXC_EN
        if (rsvd) begin
            d        = '0;
            d.exc[3] = 1'b1;
        end
`else
        // Without exception support, trap and COP0 encodings collapse to NOPs.
        if (rsvd || d.exc != 4'b0000 || d.mfc0 || d.mtc0) begin
            d = '0;
        end
`endif
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic          hazard;
    logic          accept;
    ctrl_t         q;

    assign hazard = in_valid && ex_memread && (ex_rt != 5'h00) &&
                    ((ex_rt == rs) || (ex_rt == rt));
    assign in_ready = (state == RUN) && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign div_busy = (state == DIV_WAIT);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= RUN;
            cnt   <= '0;
        end else if (flush) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        state <= LU_STALL;
                        cnt   <= CW'(LU_STALL_CYCLES - 1);
                    end else if (accept && d.div) begin
                        state <= DIV_WAIT;
                        cnt   <= CW'(DIV_CYCLES - 1);
                    end
                end
                LU_STALL, DIV_WAIT: begin
                    if (cnt == '0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            q         <= d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign regdst     = q.regdst;
    assign alusrc     = q.alusrc;
    assign regwrite   = q.regwrite;
    assign memread    = q.memread;
    assign memwrite   = q.memwrite;
    assign mem_sign   = q.mem_sign;
    assign mem_dwidth = q.mem_dwidth;
    assign aluop      = q.aluop;
    assign jmp        = q.jmp;
    assign jal        = q.jal;
    assign jr         = q.jr;
    assign jalr       = q.jalr;
    assign sftmd      = q.sftmd;
    assign div        = q.div;
    assign mfhi       = q.mfhi;
    assign mflo       = q.mflo;
    assign mthi       = q.mthi;
    assign mtlo       = q.mtlo;
    assign mfc0       = q.mfc0;
    assign mtc0       = q.mtc0;
    assign br         = q.br;
    assign exc        = q.exc;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Self-checking bench for id_ctrl_stage: directed scenarios plus a randomized
// run against a mnemonic-level decode model and a stall-counter model.
module tb_id_ctrl_stage;

    localparam int DIVC = 4;
    localparam int LUC  = 2;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       mem_sign;
        logic [1:0] mem_dwidth;
        logic [1:0] aluop;
        logic       jmp;
        logic       jal;
        logic       jr;
        logic       jalr;
        logic       sftmd;
        logic       div;
        logic       mfhi;
        logic       mflo;
        logic       mthi;
        logic       mtlo;
        logic       mfc0;
        logic       mtc0;
        logic [7:0] br;
        logic [3:0] exc;
    } exp_t;

    typedef enum {
        M_NOP, M_RSVD, M_ALU_R, M_SHIFT, M_JR, M_JALR, M_MFHI, M_MTHI,
        M_MFLO, M_MTLO, M_DIV, M_SYSCALL, M_BREAK, M_BLTZ, M_BGEZ,
        M_BLTZAL, M_BGEZAL, M_J, M_JAL, M_BEQ, M_BNE, M_BLEZ, M_BGTZ,
        M_ALU_I, M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW,
        M_MFC0, M_MTC0, M_ERET
    } mn_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction = 32'h0;
    logic        flush = 1'b0;
    logic        ex_memread = 1'b0;
    logic [4:0]  ex_rt = 5'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        regdst, alusrc, regwrite, memread, memwrite, mem_sign;
    logic [1:0]  mem_dwidth, aluop;
    logic        jmp, jal, jr, jalr, sftmd, div, mfhi, mflo, mthi, mtlo, mfc0, mtc0;
    logic [7:0]  br;
    logic [3:0]  exc;
    logic        div_busy;
    exp_t        dut_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    id_ctrl_stage #(
        .DIV_CYCLES(DIVC),
        .LU_STALL_CYCLES(LUC)
    ) dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flush(flush), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .out_valid(out_valid), .out_ready(out_ready),
        .regdst(regdst), .alusrc(alusrc), .regwrite(regwrite), .memread(memread),
        .memwrite(memwrite), .mem_sign(mem_sign), .mem_dwidth(mem_dwidth),
        .aluop(aluop), .jmp(jmp), .jal(jal), .jr(jr), .jalr(jalr), .sftmd(sftmd),
        .div(div), .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
        .mfc0(mfc0), .mtc0(mtc0), .br(br), .exc(exc), .div_busy(div_busy)
    );

    assign dut_b = {regdst, alusrc, regwrite, memread, memwrite, mem_sign,
                    mem_dwidth, aluop, jmp, jal, jr, jalr, sftmd, div,
                    mfhi, mflo, mthi, mtlo, mfc0, mtc0, br, exc};

    function automatic mn_t classify(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        op = w[31:26];
        fn = w[5:0];
        rs = w[25:21];
        rt = w[20:16];
        if (op == 6'h00) begin
            case (fn)
                6'h0C: return M_SYSCALL;
                6'h0D: return M_BREAK;
                6'h08: return M_JR;
                6'h09: return M_JALR;
                6'h10: return M_MFHI;
                6'h11: return M_MTHI;
                6'h12: return M_MFLO;
                6'h13: return M_MTLO;
                6'h1A, 6'h1B: return M_DIV;
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: return M_SHIFT;
                default: return M_ALU_R;
            endcase
        end
        case (op)
            6'h01: begin
                case (rt)
                    5'h00: return M_BLTZ;
                    5'h01: return M_BGEZ;
                    5'h10: return M_BLTZAL;
                    5'h11: return M_BGEZAL;
                    default: return M_RSVD;
                endcase
            end
            6'h02: return M_J;
            6'h03: return M_JAL;
            6'h04: return M_BEQ;
            6'h05: return M_BNE;
            6'h06: return M_BLEZ;
            6'h07: return M_BGTZ;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return M_ALU_I;
            6'h20: return M_LB;
            6'h21: return M_LH;
            6'h23: return M_LW;
            6'h24: return M_LBU;
            6'h25: return M_LHU;
            6'h28: return M_SB;
            6'h29: return M_SH;
            6'h2B: return M_SW;
            6'h10: begin
                if (rs == 5'h00) return M_MFC0;
                if (rs == 5'h04) return M_MTC0;
                if (rs == 5'h10 && fn == 6'h18) return M_ERET;
                return M_RSVD;
            end
            default: return M_RSVD;
        endcase
    endfunction

    function automatic exp_t model_decode(input logic [31:0] w);
        exp_t e;
        mn_t  m;
        e = '0;
        m = classify(w);
`ifndef CTRL_EXC_EN
        if (m inside {M_RSVD, M_SYSCALL, M_BREAK, M_ERET, M_MFC0, M_MTC0}) m = M_NOP;
`endif
        case (m)
            M_ALU_R:   begin e.regdst = 1; e.aluop = 2'b10; e.regwrite = 1; end
            M_SHIFT:   begin e.regdst = 1; e.aluop = 2'b10; e.regwrite = 1; e.sftmd = 1; end
            M_JR:      begin e.regdst = 1; e.aluop = 2'b10; e.jr = 1; end
            M_JALR:    begin e.regdst = 1; e.aluop = 2'b10; e.regwrite = 1; e.jalr = 1; end
            M_MFHI:    begin e.regdst = 1; e.aluop = 2'b10; e.regwrite = 1; e.mfhi = 1; end
            M_MFLO:    begin e.regdst = 1; e.aluop = 2'b10; e.regwrite = 1; e.mflo = 1; end
            M_MTHI:    begin e.regdst = 1; e.aluop = 2'b10; e.mthi = 1; end
            M_MTLO:    begin e.regdst = 1; e.aluop = 2'b10; e.mtlo = 1; end
            M_DIV:     begin e.regdst = 1; e.aluop = 2'b10; e.div = 1; end
            M_SYSCALL: e.exc = 4'b0010;
            M_BREAK:   e.exc = 4'b0001;
            M_ERET:    e.exc = 4'b0100;
            M_RSVD:    e.exc = 4'b1000;
            M_BLTZ:    begin e.aluop = 2'b01; e.br = 8'h20; end
            M_BGEZ:    begin e.aluop = 2'b01; e.br = 8'h10; end
            M_BLTZAL:  begin e.aluop = 2'b01; e.br = 8'h80; e.regwrite = 1; end
            M_BGEZAL:  begin e.aluop = 2'b01; e.br = 8'h40; e.regwrite = 1; end
            M_J:       e.jmp = 1;
            M_JAL:     begin e.jal = 1; e.regwrite = 1; end
            M_BEQ:     begin e.aluop = 2'b01; e.br = 8'h01; end
            M_BNE:     begin e.aluop = 2'b01; e.br = 8'h02; end
            M_BLEZ:    begin e.aluop = 2'b01; e.br = 8'h04; end
            M_BGTZ:    begin e.aluop = 2'b01; e.br = 8'h08; end
            M_ALU_I:   begin e.alusrc = 1; e.regwrite = 1; e.aluop = 2'b10; end
            M_LB:  begin e.alusrc = 1; e.regwrite = 1; e.memread = 1; e.mem_sign = 1; e.mem_dwidth = 2'b00; end
            M_LH:  begin e.alusrc = 1; e.regwrite = 1; e.memread = 1; e.mem_sign = 1; e.mem_dwidth = 2'b01; end
            M_LW:  begin e.alusrc = 1; e.regwrite = 1; e.memread = 1; e.mem_sign = 1; e.mem_dwidth = 2'b11; end
            M_LBU: begin e.alusrc = 1; e.regwrite = 1; e.memread = 1; e.mem_dwidth = 2'b00; end
            M_LHU: begin e.alusrc = 1; e.regwrite = 1; e.memread = 1; e.mem_dwidth = 2'b01; end
            M_SB:  begin e.alusrc = 1; e.memwrite = 1; e.mem_dwidth = 2'b00; end
            M_SH:  begin e.alusrc = 1; e.memwrite = 1; e.mem_dwidth = 2'b01; end
            M_SW:  begin e.alusrc = 1; e.memwrite = 1; e.mem_dwidth = 2'b11; end
            M_MFC0:    begin e.mfc0 = 1; e.regwrite = 1; end
            M_MTC0:    e.mtc0 = 1;
            default:   e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  mem_ops [8];
        mem_ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
        w = $urandom;
        case ($urandom_range(0, 7))
            0, 1: w[31:26] = 6'h00;
            2: begin
                w[31:26] = 6'h01;
                if ($urandom_range(0, 3) != 0) w[19:17] = 3'b000;
            end
            3: begin
                w[31:26] = 6'h10;
                case ($urandom_range(0, 3))
                    0: w[25:21] = 5'h00;
                    1: w[25:21] = 5'h04;
                    2: w[25:21] = 5'h10;
                    default: ;
                endcase
                if ($urandom_range(0, 1) == 1) w[5:0] = 6'h18;
            end
            4: w[31:26] = 6'($urandom_range(2, 15));
            5: w[31:26] = mem_ops[$urandom_range(0, 7)];
            default: ;
        endcase
        return w;
    endfunction

    task automatic idle(input int n);
        in_valid   = 1'b0;
        ex_memread = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || div_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got ov=%b busy=%b need 0 0", out_valid, div_busy);
        end
        n_tests++;
        if (dut_b !== exp_t'(0)) begin
            n_fail++;
            $display("FAIL reset_bundle got %h need 0", dut_b);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b need 1", in_ready);
        end
        instruction = 32'h01044022;
        in_valid    = 1'b1;
        ex_memread  = 1'b1;
        ex_rt       = 5'd8;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hazard_ready got %b need 0", in_ready);
        end
        in_valid   = 1'b0;
        ex_memread = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        idle(2);
    endtask

    task automatic test_lui();
        exp_t e;
        e = model_decode(32'h3C08FFFF);
        @(negedge clock);
        instruction = 32'h3C08FFFF;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lui_in_ready got %b need 1", in_ready);
        end
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || {regwrite, alusrc, regdst, aluop} !== 5'b11010) begin
            n_fail++;
            $display("FAIL lui_ctrl got ov=%b rw/as/rd/op=%b need 1 11010",
                     out_valid, {regwrite, alusrc, regdst, aluop});
        end
        n_tests++;
        if (dut_b !== e) begin
            n_fail++;
            $display("FAIL lui_bundle got %h need %h", dut_b, e);
        end
        idle(2);
    endtask

    task automatic test_decode_table();
        logic [31:0] words [7];
        logic [3:0]  exc_rsvd;
        logic [3:0]  exc_sys;
        exp_t        e;
        words = '{32'h1500FFFE, 32'h05910002, 32'h8C000000, 32'hFC000000,
                  32'h0000000C, 32'h0C000010, 32'h42000018};
`ifdef CTRL_EXC_EN
        exc_rsvd = 4'b1000;
        exc_sys  = 4'b0010;
`else
        exc_rsvd = 4'b0000;
        exc_sys  = 4'b0000;
`endif
        for (int i = 0; i < 7; i++) begin
            e = model_decode(words[i]);
            @(negedge clock);
            instruction = words[i];
            in_valid    = 1'b1;
            out_ready   = 1'b1;
            @(negedge clock);
            in_valid = 1'b0;
            #1;
            n_tests++;
            if (out_valid !== 1'b1 || dut_b !== e) begin
                n_fail++;
                $display("FAIL decode_%h got ov=%b %h need 1 %h", words[i], out_valid, dut_b, e);
            end
            n_tests++;
            if ((i == 0 && br !== 8'h02) ||
                (i == 1 && {br, regwrite} !== {8'h40, 1'b1}) ||
                (i == 2 && {memread, mem_dwidth, aluop} !== 5'b11100) ||
                (i == 3 && ({exc, dut_b[33:4]} !== {exc_rsvd, 30'h0})) ||
                (i == 4 && exc !== exc_sys)) begin
                n_fail++;
                $display("FAIL decode_fixed_%0d got br=%h rw=%b mr=%b dw=%b op=%b exc=%b",
                         i, br, regwrite, memread, mem_dwidth, aluop, exc);
            end
        end
        idle(2);
    endtask

    task automatic test_div();
        @(negedge clock);
        instruction = 32'h0109001A;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || div !== 1'b1) begin
            n_fail++;
            $display("FAIL div_issue got ov=%b div=%b need 1 1", out_valid, div);
        end
        for (int i = 0; i < DIVC; i++) begin
            if (i > 0) begin
                @(negedge clock);
                #1;
            end
            n_tests++;
            if (in_ready !== 1'b0 || div_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL div_hold_%0d got rdy=%b busy=%b need 0 1", i, in_ready, div_busy);
            end
        end
        @(negedge clock);
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || div_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL div_release got rdy=%b busy=%b need 1 0", in_ready, div_busy);
        end
        idle(2);
    endtask

    task automatic test_hazard();
        exp_t e;
        e = model_decode(32'h01044022);
        @(negedge clock);
        instruction = 32'h01044022;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        ex_memread  = 1'b1;
        ex_rt       = 5'd8;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_detect got %b need 0", in_ready);
        end
        @(negedge clock);
        ex_memread = 1'b0;
        #1;
        for (int i = 0; i < LUC; i++) begin
            if (i > 0) begin
                @(negedge clock);
                #1;
            end
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hazard_stall_%0d got %b need 0", i, in_ready);
            end
        end
        @(negedge clock);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_resume got %b need 1", in_ready);
        end
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || dut_b !== e) begin
            n_fail++;
            $display("FAIL hazard_issue got ov=%b %h need 1 %h", out_valid, dut_b, e);
        end
        @(negedge clock);
        instruction = 32'h00001020;
        in_valid    = 1'b1;
        ex_memread  = 1'b1;
        ex_rt       = 5'd0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_rt0 got %b need 1", in_ready);
        end
        idle(3);
    endtask

    task automatic test_hold();
        exp_t ea;
        exp_t eb;
        ea = model_decode(32'h24020005);
        eb = model_decode(32'h8C000000);
        @(negedge clock);
        instruction = 32'h24020005;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        @(negedge clock);
        instruction = 32'h8C000000;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clock);
                #1;
            end
            n_tests++;
            if (out_valid !== 1'b1 || dut_b !== ea || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d got ov=%b rdy=%b %h need 1 0 %h",
                         i, out_valid, in_ready, dut_b, ea);
            end
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release got %b need 1", in_ready);
        end
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || dut_b !== eb) begin
            n_fail++;
            $display("FAIL hold_next got ov=%b %h need 1 %h", out_valid, dut_b, eb);
        end
        idle(2);
    endtask

    task automatic test_flush_div();
        @(negedge clock);
        instruction = 32'h0109001B;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        n_tests++;
        if (div_busy !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre got busy=%b ov=%b need 1 1", div_busy, out_valid);
        end
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || div_busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_div got ov=%b busy=%b rdy=%b need 0 0 1",
                     out_valid, div_busy, in_ready);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_div();
        @(negedge clock);
        instruction = 32'h0109001A;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        #1;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (div_busy !== 1'b0 || out_valid !== 1'b0 || dut_b !== exp_t'(0) || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_div got busy=%b ov=%b rdy=%b %h need 0 0 1 0",
                     div_busy, out_valid, in_ready, dut_b);
        end
        @(negedge clock);
        resetn = 1'b1;
        idle(2);
    endtask

    task automatic test_random(input int cycles);
        exp_t exp_q;
        exp_t e_in;
        logic mov;
        int   hold;
        logic hdiv;
        logic hz;
        logic exp_rdy;
        logic acc;
        exp_q = '0;
        mov   = 1'b0;
        hold  = 0;
        hdiv  = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            in_valid    = ($urandom_range(0, 3) != 0);
            instruction = rand_instr();
            out_ready   = ($urandom_range(0, 3) != 0);
            ex_memread  = ($urandom_range(0, 5) == 0);
            ex_rt       = ($urandom_range(0, 1) == 1) ? instruction[25:21] : 5'($urandom_range(0, 31));
            flush       = ($urandom_range(0, 39) == 0);
            #1;
            hz = in_valid && ex_memread && ex_rt != 5'd0 &&
                 (ex_rt == instruction[25:21] || ex_rt == instruction[20:16]);
            exp_rdy = (hold == 0) && !hz && (!mov || out_ready);
            n_tests++;
            if (in_ready !== exp_rdy || out_valid !== mov || div_busy !== (hold > 0 && hdiv)) begin
                n_fail++;
                $display("FAIL rand_flags cyc=%0d got rdy=%b ov=%b busy=%b need %b %b %b",
                         c, in_ready, out_valid, div_busy, exp_rdy, mov, (hold > 0 && hdiv));
            end
            if (mov) begin
                n_tests++;
                if (dut_b !== exp_q) begin
                    n_fail++;
                    $display("FAIL rand_bundle cyc=%0d got %h need %h", c, dut_b, exp_q);
                end
            end
            acc  = in_valid && exp_rdy;
            e_in = model_decode(instruction);
            if (flush) begin
                hold = 0;
                mov  = 1'b0;
            end else begin
                if (hold > 0) begin
                    hold--;
                end else if (hz) begin
                    hold = LUC;
                    hdiv = 1'b0;
                end else if (acc && e_in.div) begin
                    hold = DIVC;
                    hdiv = 1'b1;
                end
                if (acc) begin
                    mov   = 1'b1;
                    exp_q = e_in;
                end else if (out_ready) begin
                    mov = 1'b0;
                end
            end
        end
        idle(DIVC + LUC + 2);
    endtask

    initial begin
        test_reset();
        test_lui();
        test_decode_table();
        test_div();
        test_hazard();
        test_hold();
        test_flush_div();
        test_reset_mid_div();
        test_random(800);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
